// File: rtl/button_events_pkg.sv
// button_events_pkg: per-lane state encoding shared by the button event lanes and the top.
// Rev 1.0
`default_nettype none

package button_events_pkg;

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    IDLE     = 2'd1,
    PRESSED  = 2'd2,
    REPEAT   = 2'd3
  } lane_state_t;

  function automatic logic is_holding(input lane_state_t s);
    return (s == PRESSED) || (s == REPEAT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_event_lane.sv
// button_event_lane: one button's press/release/long/repeat event FSM with registered pulses.
// Rev 1.0
`default_nettype none

module button_event_lane
  import button_events_pkg::*;
#(
  parameter int LONG_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int WIDTH      = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic press,
  output logic rel,       // the release pulse; "release" is a reserved word
  output logic long,
  output logic rpt,
  output logic held,
  output logic evt_next   // next-cycle value of press|rel|long|rpt, for the top's evt register
);

  localparam logic [WIDTH-1:0] LONG_LAST   = WIDTH'(LONG_CYC - 1);
  localparam logic [WIDTH-1:0] REPEAT_LAST = WIDTH'(REPEAT_CYC - 1);

  lane_state_t      state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic             press_n, rel_n, long_n, rpt_n, held_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    press_n = 1'b0;
    rel_n   = 1'b0;
    long_n  = 1'b0;
    rpt_n   = 1'b0;
    case (state)
      WAIT_REL: begin
        if (!in) state_n = IDLE;
      end
      IDLE: begin
        if (in) begin
          state_n = PRESSED;
          cnt_n   = '0;
          press_n = 1'b1;
        end
      end
      PRESSED: begin
        // Release takes priority over a coincident terminal count.
        if (!in) begin
          state_n = IDLE;
          cnt_n   = '0;
          rel_n   = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_n = REPEAT;
          cnt_n   = '0;
          long_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      REPEAT: begin
        if (!in) begin
          state_n = IDLE;
          cnt_n   = '0;
          rel_n   = 1'b1;
        end else if (cnt == REPEAT_LAST) begin
          cnt_n = '0;
          rpt_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = WAIT_REL;
        cnt_n   = '0;
      end
    endcase
    held_n   = is_holding(state_n);
    evt_next = press_n | rel_n | long_n | rpt_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_REL;
      cnt   <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
      long  <= 1'b0;
      rpt   <= 1'b0;
      held  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      press <= press_n;
      rel   <= rel_n;
      long  <= long_n;
      rpt   <= rpt_n;
      held  <= held_n;
    end
  end

endmodule

`default_nettype wire

// File: rtl/button_events.sv
// button_events: NR independent button event lanes plus a registered any-event flag.
// Rev 1.0
`default_nettype none

module button_events
  import button_events_pkg::*;
#(
  parameter int NR         = 16,
  parameter int LONG_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int WIDTH      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NR-1:0] in,
  output logic [NR-1:0] press,
  output logic [NR-1:0] rel,
  output logic [NR-1:0] long,
  output logic [NR-1:0] rpt,
  output logic [NR-1:0] held,
  output logic          evt
);

  logic [NR-1:0] lane_evt;

  generate
    for (genvar i = 0; i < NR; i++) begin : g_lane
      button_event_lane #(
        .LONG_CYC  (LONG_CYC),
        .REPEAT_CYC(REPEAT_CYC),
        .WIDTH     (WIDTH)
      ) u_lane (
        .clk     (clk),
        .rst     (rst),
        .in      (in[i]),
        .press   (press[i]),
        .rel     (rel[i]),
        .long    (long[i]),
        .rpt     (rpt[i]),
        .held    (held[i]),
        .evt_next(lane_evt[i])
      );
    end
  endgenerate

  // Built from the lanes' next values so evt lines up with the registered pulses.
  always_ff @(posedge clk) begin
    if (rst) evt <= 1'b0;
    else     evt <= |lane_evt;
  end

endmodule

`default_nettype wire

// File: tb/tb_button_events.sv
// tb_button_events: directed and random stimulus checked against a hold-time reference model.
// Rev 1.0
`default_nettype none

module tb_button_events;

  localparam int NR = 4;
  localparam int L  = 10;
  localparam int R  = 4;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] in  = '0;
  logic [NR-1:0] press, rel, long, rpt, held;
  logic          evt;

  button_events #(.NR(NR), .LONG_CYC(L), .REPEAT_CYC(R), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in(in), .press(press), .rel(rel),
    .long(long), .rpt(rpt), .held(held), .evt(evt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a lane is "blocked" until it sees in=0 after reset, then "active"
  // from a press until release; age counts edges since the press edge.
  bit            blocked [NR];
  bit            active  [NR];
  int            age     [NR];
  logic [NR-1:0] e_press, e_rel, e_long, e_rpt, e_held;
  logic          e_evt;

  task automatic model_update(input logic [NR-1:0] v, input logic r);
    e_press = '0; e_rel = '0; e_long = '0; e_rpt = '0; e_held = '0;
    for (int i = 0; i < NR; i++) begin
      if (r) begin
        blocked[i] = 1'b1;
        active[i]  = 1'b0;
        age[i]     = 0;
      end else if (blocked[i]) begin
        if (!v[i]) blocked[i] = 1'b0;
      end else if (!active[i]) begin
        if (v[i]) begin
          active[i]  = 1'b1;
          age[i]     = 0;
          e_press[i] = 1'b1;
        end
      end else begin
        age[i] = age[i] + 1;
        if (!v[i]) begin
          active[i] = 1'b0;
          e_rel[i]  = 1'b1;
        end else if (age[i] == L) begin
          e_long[i] = 1'b1;
        end else if (age[i] > L && ((age[i] - L) % R) == 0) begin
          e_rpt[i] = 1'b1;
        end
      end
      e_held[i] = active[i];
    end
    e_evt = |(e_press | e_rel | e_long | e_rpt);
  endtask

  task automatic check(input string tag, input logic [NR-1:0] obs, input logic [NR-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic step(input logic [NR-1:0] v, input logic r);
    in  = v;
    rst = r;
    @(posedge clk);
    model_update(v, r);
    #1;
    check("press", press, e_press);
    check("release", rel, e_rel);
    check("long", long, e_long);
    check("rpt", rpt, e_rpt);
    check("held", held, e_held);
    check("evt", {{(NR-1){1'b0}}, evt}, {{(NR-1){1'b0}}, e_evt});
  endtask

  task automatic steps(input int n, input logic [NR-1:0] v);
    for (int k = 0; k < n; k++) step(v, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      blocked[i] = 1'b1;
      active[i]  = 1'b0;
      age[i]     = 0;
    end

    // Button held through reset: no events until it goes 0 then 1.
    for (int k = 0; k < 3; k++) step(4'b0001, 1'b1);
    steps(20, 4'b0001);
    steps(1, 4'b0000);
    steps(3, 4'b0001);
    steps(2, 4'b0000);

    // Long press with repeats on lane 1.
    steps(30, 4'b0010);
    steps(3, 4'b0000);

    // Short press on lane 2.
    steps(5, 4'b0100);
    steps(3, 4'b0000);

    // Release on the long terminal count, then on a repeat terminal count.
    steps(L, 4'b1000);
    steps(3, 4'b0000);
    steps(L + R, 4'b1000);
    steps(3, 4'b0000);

    // All lanes together, staggered release.
    steps(3, 4'b1111);
    steps(2, 4'b0111);
    steps(2, 4'b0011);
    steps(2, 4'b0001);
    steps(3, 4'b0000);

    // Reset while lane 0 is repeating.
    steps(L + R + 2, 4'b0001);
    step(4'b0001, 1'b1);
    steps(10, 4'b0001);
    steps(1, 4'b0000);
    steps(3, 4'b0001);
    steps(2, 4'b0000);

    // Glitch: one-cycle press.
    steps(1, 4'b0100);
    steps(3, 4'b0000);

    // Random toggling with occasional reset.
    begin
      logic [NR-1:0] v;
      v = '0;
      for (int k = 0; k < 1500; k++) begin
        for (int i = 0; i < NR; i++)
          if ($urandom_range(0, 11) == 0) v[i] = ~v[i];
        step(v, ($urandom_range(0, 199) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
